// File: rtl/digitizer_capture_core.sv
// Capture engine: packs 16-bit ADC samples into 32-bit AXI-Stream beats through a
// small beat FIFO, one PKT_SIZE-byte packet per START, with a simple register bus.
module digitizer_capture_core #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    input  logic [3:0]  reg_addr,
    input  logic        reg_wr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_rd,
    output logic [31:0] reg_rdata,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pkt_size;
    logic          r_done, r_ovf;
    logic [29:0]   r_n, r_pair_cnt;
    logic          r_half;
    logic [15:0]   r_lo;
    logic          r_pend, r_pend_last;
    logic [31:0]   r_pend_data;
    logic [31:0]   r_mem      [FIFO_DEPTH];
    logic          r_mem_last [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_rdata;

    logic [29:0]   w_pkt_beats;
    logic          w_start, w_pair_done, w_pair_last;
    logic          w_full, w_push, w_drop, w_valid, w_pop, w_drain_done, w_last;

    assign w_pkt_beats  = r_pkt_size[31:2];
    assign w_start      = reg_wr && (reg_addr == 4'h0) && reg_wdata[0] && (r_state == S_IDLE);
    assign w_pair_done  = (r_state == S_CAPTURE) && sample_valid && r_half;
    assign w_pair_last  = w_pair_done && (r_pair_cnt == r_n - 30'd1);
    assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push       = r_pend && !w_full;
    assign w_drop       = r_pend && w_full;
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && m_axis_tready;
    assign w_drain_done = (r_state == S_DRAIN) && !r_pend &&
                          ((r_count == '0) || ((r_count == (AW+1)'(1)) && w_pop));
    // If the closing pair was dropped, the sole remaining entry after capture ends closes the packet.
    assign w_last       = r_mem_last[r_rd_ptr] ||
                          ((r_state == S_DRAIN) && !r_pend && (r_count == (AW+1)'(1)));

    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign m_axis_tlast  = w_valid && w_last;
    assign busy          = (r_state != S_IDLE);
    assign reg_rdata     = r_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start && (w_pkt_beats != '0)) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_pair_last)                    w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_done)                   w_state_nxt = S_IDLE;
            default:                                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pkt_size <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (reg_wr && (reg_addr == 4'h8)) r_pkt_size <= reg_wdata;
            if (w_start) begin
                r_done <= (w_pkt_beats == '0);
                r_ovf  <= 1'b0;
            end else begin
                if (reg_wr && (reg_addr == 4'h4) && reg_wdata[1]) r_done <= 1'b0;
                if (reg_wr && (reg_addr == 4'h4) && reg_wdata[2]) r_ovf  <= 1'b0;
                if (w_drain_done) r_done <= 1'b1;
                if (w_drop)       r_ovf  <= 1'b1;
            end
            if (reg_rd) begin
                case (reg_addr)
                    4'h4:    r_rdata <= {29'd0, r_ovf, r_done, busy};
                    4'h8:    r_rdata <= r_pkt_size;
                    default: r_rdata <= '0;
                endcase
            end else begin
                r_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_n         <= '0;
            r_pair_cnt  <= '0;
            r_half      <= 1'b0;
            r_lo        <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_data <= '0;
        end else begin
            r_pend <= w_pair_done;
            if (w_start) begin
                r_n        <= w_pkt_beats;
                r_pair_cnt <= '0;
                r_half     <= 1'b0;
            end else if ((r_state == S_CAPTURE) && sample_valid) begin
                if (!r_half) begin
                    r_lo   <= sample_data;
                    r_half <= 1'b1;
                end else begin
                    r_half      <= 1'b0;
                    r_pair_cnt  <= r_pair_cnt + 30'd1;
                    r_pend_data <= {sample_data, r_lo};
                    r_pend_last <= w_pair_last;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= r_pend_data;
            r_mem_last[r_wr_ptr] <= r_pend_last;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_digitizer_capture_core.sv
// Directed bench for digitizer_capture_core: register access, packing, tlast,
// overflow, START handling and asynchronous abort.
module tb_digitizer_capture_core;
    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [3:0]  reg_addr;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];

    digitizer_capture_core #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        tick;
        reg_wr = 1'b0; reg_wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        reg_addr = a; reg_rd = 1'b1;
        tick;
        reg_rd = 1'b0;
        d = reg_rdata;
    endtask

    task automatic drive_ready(input int mode);
        if (mode == 1)      m_axis_tready = 1'b1;
        else if (mode == 2) m_axis_tready = 1'($urandom % 2);
        else                m_axis_tready = 1'b0;
    endtask

    task automatic feed(input int n, input int base, input int mode, input bit gap);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'(base + i);
            drive_ready(mode);
            tick;
            if (gap) begin
                sample_valid = 1'b0;
                drive_ready(mode);
                tick;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int mode);
        int c = 0;
        while (busy && c < 5000) begin
            drive_ready(mode);
            tick;
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_pkt(input string tag, input int first, input int nbeats, input int base);
        int got  = q_data.size() - first;
        int errs = 0;
        logic [31:0] exp;
        check({tag, "_beats"}, 32'(got), 32'(nbeats));
        for (int k = 0; k < got && k < nbeats; k++) begin
            exp = {16'(base + 2*k + 1), 16'(base + 2*k)};
            if (q_data[first+k] !== exp) errs++;
            if (q_last[first+k] !== (k == nbeats - 1)) errs++;
        end
        check({tag, "_data_last_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int s;
        resetn = 1'b0; sample_data = '0; sample_valid = 1'b0;
        reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick;
        resetn = 1'b1;
        tick;

        // reset state
        rd(4'h0, d); check("rst_ctrl", d, 32'h0);
        rd(4'h4, d); check("rst_status", d, 32'h0);
        rd(4'h8, d); check("rst_pkt_size", d, 32'h0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // full-rate ramp, tready always high
        wr(4'h8, 32'd2048);
        rd(4'h8, d); check("pkt_size_rb", d, 32'd2048);
        s = q_data.size();
        wr(4'h0, 32'h1);
        feed(1024, 0, 1, 1'b0);
        wait_idle("ramp_idle", 1);
        check_pkt("ramp", s, 512, 0);
        rd(4'h4, d); check("ramp_status", d, 32'h2);

        // same packet, random back-pressure, half-rate samples
        s = q_data.size();
        wr(4'h0, 32'h1);
        feed(1024, 0, 2, 1'b1);
        wait_idle("rand_idle", 2);
        check_pkt("rand", s, 512, 0);
        rd(4'h4, d); check("rand_status", d, 32'h2);

        // overflow: stalled sink, 64-beat packet
        wr(4'h8, 32'd256);
        s = q_data.size();
        wr(4'h0, 32'h1);
        feed(200, 0, 0, 1'b0);
        check("ovf_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        check("ovf_nothing_sent", 32'(q_data.size() - s), 32'd0);
        rd(4'h4, d); check("ovf_status_busy", d, 32'h5);
        wait_idle("ovf_idle", 1);
        check_pkt("ovf", s, 16, 0);
        rd(4'h4, d); check("ovf_status_done", d, 32'h6);

        // START while busy ignored; PKT_SIZE write while busy doesn't affect packet
        wr(4'h8, 32'd64);
        s = q_data.size();
        wr(4'h0, 32'h1);
        rd(4'h4, d); check("start_clears_status", d, 32'h1);
        wr(4'h8, 32'd8);
        feed(16, 100, 1, 1'b0);
        wr(4'h0, 32'h1);
        check("busy_after_restart_try", 32'(busy), 32'd1);
        feed(16, 116, 1, 1'b0);
        wait_idle("busy_start_idle", 1);
        check_pkt("busy_start", s, 16, 100);
        rd(4'h8, d); check("pkt_size_written_busy", d, 32'd8);
        rd(4'h4, d); check("busy_start_status", d, 32'h2);

        // zero-length packet
        wr(4'h8, 32'd0);
        wr(4'h4, 32'h6);
        rd(4'h4, d); check("w1c_status", d, 32'h0);
        s = q_data.size();
        wr(4'h0, 32'h1);
        check("zero_busy", 32'(busy), 32'd0);
        rd(4'h4, d); check("zero_status", d, 32'h2);
        repeat (4) tick;
        check("zero_no_beats", 32'(q_data.size() - s), 32'd0);

        // asynchronous abort mid-packet
        wr(4'h8, 32'd256);
        wr(4'h0, 32'h1);
        feed(40, 0, 0, 1'b0);
        check("abort_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tlast", 32'(m_axis_tlast), 32'd0);
        tick;
        resetn = 1'b1;
        tick;
        rd(4'h4, d); check("abort_status", d, 32'h0);
        rd(4'h8, d); check("abort_pkt_size", d, 32'h0);
        wr(4'h8, 32'd16);
        s = q_data.size();
        wr(4'h0, 32'h1);
        feed(8, 500, 1, 1'b0);
        wait_idle("post_abort_idle", 1);
        check_pkt("post_abort", s, 4, 500);
        rd(4'h4, d); check("post_abort_status", d, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
